// File: rtl/seven_seg_scan.sv
// Time-multiplexed multi-digit 7-segment driver.
// A load strobe captures digit codes, blink enables and dash mode into shadow
// registers. The scan visits one digit per slot, blanks the first cycles of each
// slot against ghosting, and registers the decoded segments and one-hot anode.
module seven_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit AN_ACT_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  dash_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

  // Blink phase states
  localparam logic [0:0] PHASE_ON  = 1'b0;
  localparam logic [0:0] PHASE_OFF = 1'b1;

  // Inversion masks applied to the active-high internal values
  localparam logic [6:0]        SEG_INV = {7{SEG_ACT_LOW}};
  localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{AN_ACT_LOW}};

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   blink_q, blink_d;
  logic                dash_q, dash_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [0:0]          phase_q, phase_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                slot_wrap;
  logic                in_blank;
  logic [3:0]          cur_code;
  logic                cur_blink;
  logic [3:0]          code_w [DIGITS];

  // Active-high gfedcba decode; codes B..E are blank, F is blank or a dash
  function automatic logic [6:0] decode(input logic [3:0] code, input logic dash);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hF:    s = dash ? 7'b1000000 : 7'b0000000;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Split the packed shadow word into per-digit codes
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_code
      assign code_w[gi] = shadow_q[4*gi +: 4];
    end
  endgenerate

  assign slot_wrap  = (slot_q == SLOT_LAST);
  assign frame_tick = slot_wrap && (idx_q == IDX_LAST);
  assign in_blank   = (BLANK_CYC > 0) && (slot_q < SLOT_W'(BLANK_CYC));

  // Scan position, blink timing and shadow capture
  always_comb begin
    slot_d   = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    blink_d  = blink_q;
    dash_d   = dash_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (frame_tick) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    if (load) begin
      shadow_d = digits_in;
      blink_d  = blink_in;
      dash_d   = dash_en;
    end
  end

  // Select the code and blink enable of the digit currently being scanned
  always_comb begin
    cur_code  = 4'hF;
    cur_blink = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code  = code_w[i];
        cur_blink = blink_q[i];
      end
    end
  end

  // Next pin values from the pre-edge scan state and shadow contents
  always_comb begin
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;
    an_raw = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_raw[i] = (idx_q == IDX_W'(i));
    end
    seg_raw = decode(cur_code, dash_q);
    if (in_blank) begin
      an_raw  = '0;
      seg_raw = '0;
    end else if ((phase_q == PHASE_OFF) && cur_blink) begin
      seg_raw = '0;
    end
    seg_d = seg_raw ^ SEG_INV;
    an_d  = an_raw ^ AN_INV;
  end

  // State and output registers, asynchronously cleared to the idle display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '1;
      blink_q  <= '0;
      dash_q   <= 1'b0;
      slot_q   <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      phase_q  <= PHASE_ON;
      seg_q    <= SEG_INV;
      an_q     <= AN_INV;
    end else begin
      shadow_q <= shadow_d;
      blink_q  <= blink_d;
      dash_q   <= dash_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with a 4-digit, 8-cycle-slot, 2-frame-blink setup.
// A reference model derives the expected pins from the cycle count since reset
// and the most recently loaded data; table vectors and hand sequences add
// fixed expectations for decode, blink, reset and load-at-wrap behaviour.
module tb_seven_seg_scan;

  localparam int DIGITS = 4;
  localparam int SDIV   = 8;
  localparam int BLANK  = 2;
  localparam int BFR    = 2;
  localparam int FRAME  = SDIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  blink_in = 4'h0;
  logic        dash_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad = 0;

  seven_seg_scan #(
    .DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_CYC(BLANK), .BLINK_FRAMES(BFR),
    .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blink_in(blink_in), .dash_en(dash_en), .seg(seg), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Segment pattern of a code, straight from the decode table
  function automatic logic [6:0] glyph(input logic [3:0] code, input logic dash);
    case (code)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77;
      4'hF: return dash ? 7'h40 : 7'h00;
      default: return 7'h00;
    endcase
  endfunction

  // What the display should show for scan cycle c (cycles since reset release)
  function automatic logic [6:0] model_seg(input int c, input logic [15:0] dig,
                                           input logic [3:0] blk, input logic dash);
    int slot, idx, frame;
    slot  = c % SDIV;
    idx   = (c / SDIV) % DIGITS;
    frame = c / FRAME;
    if (slot < BLANK) return 7'h00;
    if (((frame / BFR) % 2) == 1 && blk[idx]) return 7'h00;
    return glyph(dig[idx*4 +: 4], dash);
  endfunction

  function automatic logic [3:0] model_an(input int c);
    if ((c % SDIV) < BLANK) return 4'h0;
    return 4'(1 << ((c / SDIV) % DIGITS));
  endfunction

  // Reference model: pins after an edge reflect the cycle before it
  int          m_cnt = 0;
  logic [15:0] m_dig = 16'hFFFF;
  logic [3:0]  m_blk = 4'h0;
  logic        m_dash = 1'b0;
  logic [6:0]  exp_seg = 7'h00;
  logic [3:0]  exp_an = 4'h0;
  bit          chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_dig <= 16'hFFFF; m_blk <= 4'h0; m_dash <= 1'b0;
      exp_seg <= 7'h00; exp_an <= 4'h0;
    end else begin
      exp_seg <= model_seg(m_cnt, m_dig, m_blk, m_dash);
      exp_an  <= model_an(m_cnt);
      if (load) begin
        m_dig <= digits_in; m_blk <= blink_in; m_dash <= dash_en;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("scan_seg", 32'(seg), 32'(exp_seg));
      check("scan_an", 32'(an), 32'(exp_an));
      check("scan_tick", 32'(frame_tick), 32'((m_cnt % FRAME) == FRAME - 1));
    end
  end

  typedef struct {
    logic [15:0]     dig;
    logic [3:0]      blk;
    logic            dash;
    logic [3:0][6:0] exp;
  } vec_t;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_an", 32'(an), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic ds);
    @(negedge clk);
    digits_in = d; blink_in = b; dash_en = ds; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_an(input int d, input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (an == 4'(1 << d)) found = 1'b1;
    end
    check({nm, "_reach"}, 32'(found), 32'h1);
  endtask

  vec_t vecs [9];

  initial begin
    int ft;
    vecs[0] = '{16'h1250, 4'h0, 1'b0, {7'h06, 7'h5B, 7'h6D, 7'h3F}};
    vecs[1] = '{16'hFFF3, 4'h0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h4F}};
    vecs[2] = '{16'hFFF3, 4'h0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h4F}};
    vecs[3] = '{16'h8888, 4'h5, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[4] = '{16'h4567, 4'h0, 1'b0, {7'h66, 7'h6D, 7'h7D, 7'h07}};
    vecs[5] = '{16'h89A0, 4'h0, 1'b1, {7'h7F, 7'h6F, 7'h77, 7'h3F}};
    vecs[6] = '{16'hFFFA, 4'h0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h77}};
    vecs[7] = '{16'hDCBE, 4'h0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[8] = '{16'hFFFB, 4'h0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}};

    // Idle scan after reset: blank segments, anode walk, frame tick rate
    do_reset();
    chk_en = 1'b1;
    ft = 0;
    repeat (96) begin
      @(negedge clk);
      if (frame_tick) ft++;
    end
    check("idle_tick_count", 32'(ft), 32'd3);
    $display("idle scan checked, frame ticks=%0d", ft);

    // Table vectors: each digit's first visible cycle after a fresh load
    for (int v = 0; v < 9; v++) begin
      do_reset();
      do_load(vecs[v].dig, vecs[v].blk, vecs[v].dash);
      for (int d = 0; d < DIGITS; d++) begin
        wait_an(d, "vec");
        check($sformatf("vec%0d_d%0d", v, d), 32'(seg), 32'(vecs[v].exp[d]));
      end
      $display("vector %0d digits=%h blink=%b dash=%0d applied", v, vecs[v].dig, vecs[v].blk, vecs[v].dash);
    end

    // Blink: digits 0 and 2 go dark in frames 2-3, back on in frames 4-5
    do_reset();
    do_load(16'h8888, 4'b0101, 1'b0);
    while (m_cnt < 2 * BFR * FRAME / 2 + 2) @(negedge clk);
    for (int d = 0; d < DIGITS; d++) begin
      wait_an(d, "blink_off");
      check($sformatf("blink_off_d%0d", d), 32'(seg), (d % 2 == 0) ? 32'h00 : 32'h7F);
    end
    while (m_cnt < 2 * BFR * FRAME + 2) @(negedge clk);
    wait_an(0, "blink_on");
    check("blink_on_d0", 32'(seg), 32'h7F);
    $display("blink sequence done at cycle %0d", m_cnt);

    // Load on the wrap edge into digit 1
    do_reset();
    do_load(16'h1111, 4'h0, 1'b0);
    while (m_cnt != SDIV - 1) @(negedge clk);
    digits_in = 16'h0030; blink_in = 4'h0; dash_en = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_an(1, "wrap");
    check("wrap_load_d1", 32'(seg), 32'h4F);
    $display("load at slot wrap done, seg=%b", seg);

    // Asynchronous reset in the middle of digit 2's slot
    do_reset();
    do_load(16'h8888, 4'h0, 1'b0);
    while (m_cnt != 2 * SDIV + 4) @(negedge clk);
    check("mid_pre_an", 32'(an), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'h0);
    check("mid_rst_seg", 32'(seg), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (an != 4'h0) seen = 1'b1;
      end
      check("mid_resume_seen", 32'(seen), 32'h1);
      check("mid_resume_an", 32'(an), 32'h1);
      check("mid_resume_seg", 32'(seg), 32'h0);
    end
    $display("mid-slot reset done, an=%b seg=%b", an, seg);

    // Random loads, including back-to-back strobes, against the model
    do_reset();
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_load(16'($urandom), 4'($urandom), 1'($urandom));
      $display("random load %0d digits=%h blink=%b dash=%0d", r, digits_in, blink_in, dash_en);
    end
    repeat (3 * FRAME) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
